// File: rtl/pipe_add_const_stream.sv
// pipe_add_const_stream
//   Streaming "x + INCREMENT" pipeline with valid/ready flow control.
//   Stage 0 registers the raw operand. The WIDTH+1 bit add sits between
//   stage 0 and stage 1. Stages 1..STAGES-1 carry the sum and carry.
//   Empty stages are filled even while the output is stalled, so bubbles
//   collapse. There is no skid buffer: in_ready depends combinationally
//   on out_ready.
//
// Parameters
//   WIDTH      data width in bits (>= 1)
//   STAGES     number of register stages (>= 1)
//   INCREMENT  constant added, truncated to WIDTH bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all in-flight data
//   in_valid   producer has data
//   in_ready   block accepts data this cycle
//   in_data    operand x
//   out_valid  out_data/out_carry valid
//   out_ready  consumer accepts this cycle
//   out_data   (x + INCREMENT) mod 2^WIDTH, or saturated
//   out_carry  carry out of the WIDTH-bit add
//   occupancy  registered count of valid stages
//
// Build option
//   PIPE_ADD_CONST_STREAM_SATURATE_EN : when defined, an add that carries
//   drives out_data to all-ones. out_carry is still 1 in that case.

module pipe_add_const_stream #(
   parameter int WIDTH     = 32,
   parameter int STAGES    = 2,
   parameter int INCREMENT = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_carry,
   output logic [$clog2(STAGES+1)-1:0] occupancy
);

   localparam int          OW   = $clog2(STAGES+1);
   localparam int unsigned LAST = STAGES - 1;
   localparam logic [WIDTH-1:0] INC = WIDTH'(INCREMENT);

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] adv;        // stage i may take new content this cycle
   logic [WIDTH-1:0]  x_q;
   logic [WIDTH:0]    sum_full;
   logic [WIDTH-1:0]  add_data;
   logic              add_carry;
   logic              accept;
   logic              emit;
   logic [OW-1:0]     occ_q;

   // Arithmetic between stage 0 and stage 1
   always_comb begin
      sum_full  = {1'b0, x_q} + {1'b0, INC};
      add_carry = sum_full[WIDTH];
      add_data  = sum_full[WIDTH-1:0];
`ifdef PIPE_ADD_CONST_STREAM_SATURATE_EN
      if (add_carry) add_data = '1;
`endif
   end

   // Stage i can advance if the output is being taken, or if any stage at
   // or beyond i is empty. Writing this as a running AND from the last
   // stage keeps the chain free of self-referencing combinational loops.
   always_comb begin
      logic full_run;
      full_run = 1'b1;
      adv      = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         full_run       = full_run & valid_q[LAST-k];
         adv[LAST-k]    = out_ready | ~full_run;
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = valid_q[LAST];
   assign accept    = in_valid & in_ready;
   assign emit      = valid_q[LAST] & out_ready;
   assign occupancy = occ_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         if (adv[0]) valid_q[0] <= in_valid;
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k]) valid_q[k] <= valid_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else begin
         case ({accept, emit})
            2'b10:   occ_q <= occ_q + OW'(1);
            2'b01:   occ_q <= occ_q - OW'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Operand register: contents are meaningless while valid_q[0] is 0
   always_ff @(posedge clk) begin
      if (adv[0]) x_q <= in_data;
   end

   // The output is masked with the last valid bit, which gives 0 on reset
   // and on any empty cycle while leaving data registers unreset.
   generate
      if (STAGES == 1) begin : g_comb_out
         assign out_data  = valid_q[0] ? add_data : '0;
         assign out_carry = valid_q[0] & add_carry;
      end else begin : g_reg_out
         logic [WIDTH-1:0] sum_q   [1:LAST];
         logic             carry_q [1:LAST];

         always_ff @(posedge clk) begin
            if (adv[1]) begin
               sum_q[1]   <= add_data;
               carry_q[1] <= add_carry;
            end
            for (int unsigned k = 2; k <= LAST; k++) begin
               if (adv[k]) begin
                  sum_q[k]   <= sum_q[k-1];
                  carry_q[k] <= carry_q[k-1];
               end
            end
         end

         assign out_data  = valid_q[LAST] ? sum_q[LAST] : '0;
         assign out_carry = valid_q[LAST] & carry_q[LAST];
      end
   endgenerate

endmodule

// File: tb/tb_pipe_add_const_stream.sv
// Testbench for pipe_add_const_stream.
// Two instances are used. dut_a has the default parameters (WIDTH=32,
// STAGES=2, INCREMENT=1). dut_b has WIDTH=8, STAGES=4, INCREMENT=1.
module tb_pipe_add_const_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // dut_a signals
   logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic [31:0] a_in_data = '0;
   logic        a_in_ready, a_out_valid, a_out_carry;
   logic [31:0] a_out_data;
   logic [1:0]  a_occupancy;

   // dut_b signals
   logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic [7:0]  b_in_data = '0;
   logic        b_in_ready, b_out_valid, b_out_carry;
   logic [7:0]  b_out_data;
   logic [2:0]  b_occupancy;

   pipe_add_const_stream #(.WIDTH(32), .STAGES(2), .INCREMENT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_carry(a_out_carry), .occupancy(a_occupancy));

   pipe_add_const_stream #(.WIDTH(8), .STAGES(4), .INCREMENT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_carry(b_out_carry), .occupancy(b_occupancy));

   int checks = 0;
   int failures = 0;

   logic [32:0] qa[$];
   logic [8:0]  qb[$];
   logic [32:0] a_exp_next;
   logic [8:0]  b_exp_next;
   logic        a_acc_last, b_acc_last;
   int          occ_a = 0, occ_b = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] d;
      logic        c;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference behaviour of the 8-bit instance
   function automatic logic [8:0] exp_b(input logic [7:0] x);
      logic [8:0] s;
      s = {1'b0, x} + 9'd1;
`ifdef PIPE_ADD_CONST_STREAM_SATURATE_EN
      if (s[8]) s[7:0] = 8'hFF;
`endif
      return s;
   endfunction

   function automatic logic [32:0] exp_a(input logic [31:0] x);
      logic [32:0] s;
      s = {1'b0, x} + 33'd1;
`ifdef PIPE_ADD_CONST_STREAM_SATURATE_EN
      if (s[32]) s[31:0] = 32'hFFFF_FFFF;
`endif
      return s;
   endfunction

   // Called just after a falling edge with inputs already set. Records the
   // handshakes that the next rising edge will perform. After that edge it
   // checks occupancy against a count built from those handshakes.
   task automatic tick();
      logic a_emit, b_emit;
      logic [32:0] ea;
      logic [8:0]  eb;
      #1;
      a_acc_last = a_in_valid && a_in_ready && !a_flush;
      b_acc_last = b_in_valid && b_in_ready && !b_flush;
      a_emit = a_out_valid && a_out_ready && !a_flush;
      b_emit = b_out_valid && b_out_ready && !b_flush;
      if (a_emit) begin
         if (qa.size() == 0) chk("a_unexpected_out", {a_out_carry, a_out_data}, 64'hDEAD);
         else begin
            ea = qa.pop_front();
            chk("a_data", {a_out_carry, a_out_data}, ea);
         end
      end
      if (b_emit) begin
         if (qb.size() == 0) chk("b_unexpected_out", {b_out_carry, b_out_data}, 64'hDEAD);
         else begin
            eb = qb.pop_front();
            chk("b_data", {b_out_carry, b_out_data}, eb);
         end
      end
      if (a_acc_last) qa.push_back(a_exp_next);
      if (b_acc_last) qb.push_back(b_exp_next);
      if (a_flush) begin qa.delete(); occ_a = 0; end
      else occ_a = occ_a + int'(a_acc_last) - int'(a_emit);
      if (b_flush) begin qb.delete(); occ_b = 0; end
      else occ_b = occ_b + int'(b_acc_last) - int'(b_emit);
      @(posedge clk);
      @(negedge clk);
      chk("a_occ", a_occupancy, occ_a);
      chk("b_occ", b_occupancy, occ_b);
   endtask

   // Present one word to dut_b and wait, with a bound, until it is accepted
   task automatic send_b(input logic [7:0] x, input string name);
      b_in_valid = 1'b1;
      b_in_data  = x;
      b_exp_next = exp_b(x);
      b_acc_last = 1'b0;
      for (int n = 0; n < 20 && !b_acc_last; n++) tick();
      chk(name, b_acc_last, 1);
      b_in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int sent;
      logic stall_prev;
      logic [8:0] held;
      logic saw_full, saw_nready;

      tbl[0] = '{32'h0000_0000, 32'h0000_0001, 1'b0};
      tbl[1] = '{32'h0000_0001, 32'h0000_0002, 1'b0};
      tbl[2] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0};
      tbl[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0};
`ifdef PIPE_ADD_CONST_STREAM_SATURATE_EN
      tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
`else
      tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
`endif
      tbl[5] = '{32'h1234_5678, 32'h1234_5679, 1'b0};

      // Reset / idle
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_occ",   a_occupancy, 0);
      chk("rst_a_ready", a_in_ready, 1);
      chk("rst_a_data",  a_out_data, 0);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_b_occ",   b_occupancy, 0);
      chk("rst_b_ready", b_in_ready, 1);
      chk("rst_b_data",  b_out_data, 0);
      @(negedge clk);

      // Streaming on dut_a, including latency and throughput
      a_out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = i;
         a_exp_next = {1'b0, 32'(i + 1)};
         tick();
         if (i == 0) chk("a_latency_early", a_out_valid, 0);
         else        chk("a_stream_valid", a_out_valid, 1);
      end
      a_in_valid = 1'b0;
      drain(4);
      chk("a_stream_drained", qa.size(), 0);

      // Table vectors on dut_a (the sum is the required value, not a model)
      for (int v = 0; v < 6; v++) begin
         a_in_valid = 1'b1;
         a_in_data  = tbl[v].x;
         a_exp_next = {tbl[v].c, tbl[v].d};
         a_acc_last = 1'b0;
         for (int n = 0; n < 20 && !a_acc_last; n++) tick();
         chk("a_tbl_accept", a_acc_last, 1);
         chk("a_tbl_model", exp_a(tbl[v].x), {tbl[v].c, tbl[v].d});
      end
      a_in_valid = 1'b0;
      drain(4);
      chk("a_tbl_drained", qa.size(), 0);

      // Wrap on dut_b
      b_out_ready = 1'b1;
      send_b(8'hFF, "b_wrap_accept");
      drain(6);
      chk("b_wrap_drained", qb.size(), 0);

      // Backpressure on dut_b: 10 words, out_ready low for cycles 5..12
      sent = 0; stall_prev = 1'b0; held = '0; saw_full = 1'b0; saw_nready = 1'b0;
      for (int cyc = 0; cyc < 80 && !(sent == 10 && qb.size() == 0); cyc++) begin
         b_out_ready = !(cyc >= 5 && cyc <= 12);
         b_in_valid  = (sent < 10);
         b_in_data   = 8'hF8 + 8'(sent);
         b_exp_next  = exp_b(8'hF8 + 8'(sent));
         stall_prev  = b_out_valid && !b_out_ready;
         held        = {b_out_carry, b_out_data};
         tick();
         if (b_acc_last) sent++;
         if (stall_prev) chk("b_stall_hold", {b_out_carry, b_out_data}, held);
         if (b_occupancy == 3'd4) saw_full = 1'b1;
         if (!b_in_ready && !b_out_ready) saw_nready = 1'b1;
      end
      b_in_valid = 1'b0;
      chk("b_bp_all_sent", sent, 10);
      chk("b_bp_drained", qb.size(), 0);
      chk("b_bp_full", saw_full, 1);
      chk("b_bp_not_ready", saw_nready, 1);

      // Flush with 3 words in flight
      b_out_ready = 1'b0;
      send_b(8'h30, "b_fl_acc0");
      send_b(8'h31, "b_fl_acc1");
      send_b(8'h32, "b_fl_acc2");
      chk("b_fl_occ3", b_occupancy, 3);
      b_flush = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h55; b_exp_next = exp_b(8'h55);
      tick();
      b_flush = 1'b0; b_in_valid = 1'b0;
      chk("b_fl_occ0", b_occupancy, 0);
      chk("b_fl_valid0", b_out_valid, 0);
      b_out_ready = 1'b1;
      send_b(8'h10, "b_fl_post0");
      send_b(8'h20, "b_fl_post1");
      drain(8);
      chk("b_fl_drained", qb.size(), 0);

      // Asynchronous reset mid-stream
      b_out_ready = 1'b0;
      send_b(8'h40, "b_ar_acc0");
      send_b(8'h41, "b_ar_acc1");
      send_b(8'h42, "b_ar_acc2");
      chk("b_ar_occ3", b_occupancy, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("b_ar_valid0", b_out_valid, 0);
      chk("b_ar_occ0",   b_occupancy, 0);
      qa.delete(); qb.delete(); occ_a = 0; occ_b = 0;
      @(negedge clk);
      rst_n = 1'b1;
      b_out_ready = 1'b1;
      send_b(8'h70, "b_ar_post0");
      send_b(8'h71, "b_ar_post1");
      send_b(8'h72, "b_ar_post2");
      drain(8);
      chk("b_ar_drained", qb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pipe_add_const_stream.md
Name: pipe_add_const_stream

Overview:
- Parametrised successor to the fixed two-stage "x + 1" pipeline.
- Computes out = in + INCREMENT over a configurable number of register stages.
- Adds valid/ready flow control with bubble collapsing, a synchronous flush, a carry flag and an occupancy count.
- Sits between streaming producer and consumer blocks; replaces hand-instantiated per-cycle stage modules.

Parameters:
- WIDTH, 32, data width in bits (>= 1).
- STAGES, 2, number of register stages (>= 1); stage 0 registers the input.
- INCREMENT, 1, constant added; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all in-flight data
- in_valid  input  1  producer has data
- in_ready  output  1  block accepts data this cycle
- in_data  input  WIDTH  operand x
- out_valid  output  1  out_data/out_carry valid
- out_ready  input  1  consumer accepts this cycle
- out_data  output  WIDTH  (x + INCREMENT) mod 2^WIDTH, or saturated (see Optional Feature)
- out_carry  output  1  carry out of the WIDTH-bit add
- occupancy  output  $clog2(STAGES+1)  count of valid stages

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all stage valid bits 0, so out_valid=0 and occupancy=0; out_data and out_carry 0; in_ready=1 once reset is released.
- Stage structure: stage 0 holds the raw x. The add is combinational between stage 0 and stage 1. When STAGES=1, the output is the combinational add of stage 0. When STAGES>=2, the sum and carry move through stages 1..STAGES-1 and the output is driven from the last stage register.
- Advance rule: last stage moves when out_ready or its valid bit is 0. Stage i loads from stage i-1 when stage i is empty or stage i moves. Stage 0 loads when in_valid && in_ready.
- in_ready = !valid[0] || stage0_moves. It is a combinational path from out_ready through the chain; no skid buffer.
- Bubbles collapse: a stalled output does not block upstream stages that have empty slots.
- Latency: a word accepted at edge E shows out_valid=1 in the cycle after edge E+STAGES-1, provided no stall. Throughput is 1 word/cycle while out_ready=1.
- Ordering: strictly in order, no drops, no duplicates.
- Stall hold: while out_valid && !out_ready, out_data and out_carry stay stable.
- Arithmetic: the sum is computed at WIDTH+1 bits. out_data is the low WIDTH bits; out_carry is the MSB. Wrap-around is legal, e.g. all-ones + 1 gives 0 with carry=1.
- flush: on the next edge all valid bits clear and occupancy becomes 0. A word presented in the same cycle is dropped; in_ready may read 1 during that cycle.
- occupancy: registered count of set valid bits. Accept without emit adds 1; emit without accept subtracts 1; simultaneous accept and emit leaves it unchanged. flush forces 0.
- Reset mid-operation: all in-flight data is lost immediately; outputs take their reset values without waiting for a clock edge.
- Data registers of empty stages need no reset; only valid bits and the output registers are reset.

Optional Feature:
- Macro: PIPE_ADD_CONST_STREAM_SATURATE_EN.
- Defined: when the add carries, out_data is forced to all-ones and out_carry is still 1.
- Undefined: wrapping modulo 2^WIDTH as described in Behaviour.
- Port list is identical in both builds.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release → out_valid=0, occupancy=0, in_ready=1, out_data=0.
- Streaming, default params: present x=0,1,2,… back-to-back with out_ready=1 → out_data=1,2,3,… with out_valid first high 2 cycles after the first accept, one result per cycle, out_carry=0.
- Wrap, WIDTH=8, INCREMENT=1: x=8'hFF → out_data=8'h00, out_carry=1. With SATURATE_EN defined → out_data=8'hFF, out_carry=1.
- Backpressure, STAGES=4: stream 10 words with out_ready low for cycles 5–12 → occupancy reaches 4, in_ready=0, out_data held stable; all 10 results arrive in order with no loss after out_ready rises.
- Flush with 3 words in flight (STAGES=4): assert flush for 1 cycle together with in_valid → occupancy=0 next cycle, out_valid=0; none of the flushed words ever appear at the output.
- Async reset mid-stream: drop rst_n between clock edges while occupancy=3 → out_valid and occupancy go to 0 before the next edge; after release, new words are processed normally.
